// File: rtl/sad_search_host.sv
// sad_search_host: drives one original block and N candidate blocks through a SAD core, tracking the minimum SAD
//   i_clk/i_rst_n           clock, asynchronous active-low reset
//   i_start, i_num_cand     search request and candidate count (latched at start)
//   i_ori_in                original block, pixel k at [k*WIDTH +: WIDTH]
//   o_cand_addr/o_cand_rd   candidate RAM read port, data valid on i_cand_data next cycle
//   o_ori_bus/o_can_bus     registered blocks to the SAD core
//   o_init/o_finish/o_ack   SAD core handshake master side; i_done/i_out_sad core result
//   o_busy/o_result_valid   search activity and one-cycle result strobe
//   o_best_sad/o_best_idx   minimum SAD and its candidate index; o_timeout_err abort flag
module sad_search_host #(
  parameter int WIDTH   = 8,
  parameter int IDX_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [IDX_W-1:0]      i_num_cand,
  input  logic [32*WIDTH-1:0]   i_ori_in,
  output logic [IDX_W-1:0]      o_cand_addr,
  output logic                  o_cand_rd,
  input  logic [32*WIDTH-1:0]   i_cand_data,
  output logic [32*WIDTH-1:0]   o_ori_bus,
  output logic [32*WIDTH-1:0]   o_can_bus,
  output logic                  o_init,
  output logic                  o_finish,
  output logic                  o_ack,
  input  logic                  i_done,
  input  logic [WIDTH+4:0]      i_out_sad,
  output logic                  o_busy,
  output logic                  o_result_valid,
  output logic [WIDTH+4:0]      o_best_sad,
  output logic [IDX_W-1:0]      o_best_idx,
  output logic                  o_timeout_err
);
  localparam int SW = WIDTH + 5;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_INIT   = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;
  localparam logic [2:0] S_ACK    = 3'd5;
  localparam logic [2:0] S_NEXT   = 3'd6;
  localparam logic [2:0] S_RESULT = 3'd7;
  logic [2:0]          r_state;
  logic [2:0]          w_nxt;
  logic [IDX_W-1:0]    r_num;
  logic [IDX_W-1:0]    r_idx;
  logic [TW-1:0]       r_tmr;
  logic [32*WIDTH-1:0] r_ori;
  logic [32*WIDTH-1:0] r_can;
  logic [SW-1:0]       r_best_sad;
  logic [IDX_W-1:0]    r_best_idx;
  logic                r_terr;
  logic                r_cand_rd;
  logic                r_init;
  logic                r_finish;
  logic                r_ack;
  logic                r_busy;
  logic                r_rv;
  logic                w_last;
  logic                w_tmo;
  assign w_last = r_idx == r_num - IDX_W'(1);
  assign w_tmo  = r_tmr == TW'(TIMEOUT - 1);
  // done has priority over the timeout in FIN
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   w_nxt = !i_start ? S_IDLE : (i_num_cand == '0) ? S_RESULT : S_FETCH;
      S_FETCH:  w_nxt = S_LOAD;
      S_LOAD:   w_nxt = S_INIT;
      S_INIT:   w_nxt = S_FIN;
      S_FIN:    w_nxt = i_done ? S_ACK : w_tmo ? S_RESULT : S_FIN;
      S_ACK:    w_nxt = i_done ? S_ACK : S_NEXT;
      S_NEXT:   w_nxt = w_last ? S_RESULT : S_FETCH;
      default:  w_nxt = S_IDLE;
    endcase
  end
  // handshake and strobe outputs are registered from the next state so each is glitch-free
  // and aligned exactly with the state it belongs to
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_num      <= '0;
      r_idx      <= '0;
      r_tmr      <= '0;
      r_ori      <= '0;
      r_can      <= '0;
      r_best_sad <= '0;
      r_best_idx <= '0;
      r_terr     <= 1'b0;
      r_cand_rd  <= 1'b0;
      r_init     <= 1'b0;
      r_finish   <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_rv       <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_cand_rd <= w_nxt == S_FETCH;
      r_init    <= w_nxt == S_INIT;
      r_finish  <= w_nxt == S_FIN;
      r_ack     <= w_nxt == S_ACK;
      r_rv      <= w_nxt == S_RESULT;
      r_busy    <= w_nxt != S_IDLE;
      r_tmr     <= (r_state == S_FIN) ? r_tmr + TW'(1) : '0;
      if (r_state == S_IDLE && i_start) begin
        r_num      <= i_num_cand;
        r_ori      <= i_ori_in;
        r_idx      <= '0;
        r_best_sad <= '1;
        r_best_idx <= '0;
        r_terr     <= 1'b0;
      end
      if (r_state == S_LOAD)
        r_can <= i_cand_data;
      // strict compare keeps the lower index on ties
      if (r_state == S_FIN && i_done && i_out_sad < r_best_sad) begin
        r_best_sad <= i_out_sad;
        r_best_idx <= r_idx;
      end
      if (r_state == S_FIN && !i_done && w_tmo)
        r_terr <= 1'b1;
      if (r_state == S_NEXT && !w_last)
        r_idx <= r_idx + IDX_W'(1);
    end
  end
  assign o_cand_addr    = r_idx;
  assign o_cand_rd      = r_cand_rd;
  assign o_ori_bus      = r_ori;
  assign o_can_bus      = r_can;
  assign o_init         = r_init;
  assign o_finish       = r_finish;
  assign o_ack          = r_ack;
  assign o_busy         = r_busy;
  assign o_result_valid = r_rv;
  assign o_best_sad     = r_best_sad;
  assign o_best_idx     = r_best_idx;
  assign o_timeout_err  = r_terr;
endmodule

// File: tb/tb_sad_search_host.sv
// tb_sad_search_host: directed scenarios for sad_search_host with a behavioural SAD core and candidate RAM
module tb_sad_search_host;
  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [7:0]   i_num_cand = '0;
  logic [255:0] i_ori_in = '0;
  logic [7:0]   o_cand_addr;
  logic         o_cand_rd;
  logic [255:0] i_cand_data = '0;
  logic [255:0] o_ori_bus;
  logic [255:0] o_can_bus;
  logic         o_init;
  logic         o_finish;
  logic         o_ack;
  logic         i_done = 1'b0;
  logic [12:0]  i_out_sad = '0;
  logic         o_busy;
  logic         o_result_valid;
  logic [12:0]  o_best_sad;
  logic [7:0]   o_best_idx;
  logic         o_timeout_err;

  sad_search_host #(.WIDTH(8), .IDX_W(8), .TIMEOUT(64)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_num_cand(i_num_cand),
    .i_ori_in(i_ori_in), .o_cand_addr(o_cand_addr), .o_cand_rd(o_cand_rd),
    .i_cand_data(i_cand_data), .o_ori_bus(o_ori_bus), .o_can_bus(o_can_bus),
    .o_init(o_init), .o_finish(o_finish), .o_ack(o_ack), .i_done(i_done),
    .i_out_sad(i_out_sad), .o_busy(o_busy), .o_result_valid(o_result_valid),
    .o_best_sad(o_best_sad), .o_best_idx(o_best_idx), .o_timeout_err(o_timeout_err)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int core_lat = 3;
  int ack_hold = 0;
  bit never_done = 1'b0;
  int f_cnt = 0;
  int a_cnt = 0;
  int n_init = 0, n_rd = 0, n_fin = 0, n_ack = 0, n_rv = 0, n_excl = 0;
  logic [255:0] ram [0:7];

  function automatic logic [255:0] fill(input logic [7:0] v);
    return {32{v}};
  endfunction

  function automatic logic [255:0] pix0(input logic [7:0] v);
    logic [255:0] b;
    b = '0;
    b[7:0] = v;
    return b;
  endfunction

  function automatic logic [12:0] sad(input logic [255:0] a, input logic [255:0] b);
    int s;
    s = 0;
    for (int k = 0; k < 32; k++)
      s += (a[k*8 +: 8] > b[k*8 +: 8]) ? int'(a[k*8 +: 8]) - int'(b[k*8 +: 8])
                                       : int'(b[k*8 +: 8]) - int'(a[k*8 +: 8]);
    return 13'(s);
  endfunction

  always @(posedge i_clk)
    if (o_cand_rd) i_cand_data <= ram[o_cand_addr[2:0]];

  // SAD core model: done core_lat cycles into finish, held until ack has been seen ack_hold+1 times
  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        i_done = 1'b0;
        f_cnt = 0;
        a_cnt = 0;
      end else if (i_done) begin
        if (o_ack) begin
          if (a_cnt == ack_hold) begin
            i_done = 1'b0;
            a_cnt = 0;
          end else a_cnt++;
        end
      end else if (o_finish && !never_done) begin
        f_cnt++;
        if (f_cnt == core_lat) begin
          i_done = 1'b1;
          i_out_sad = sad(o_ori_bus, o_can_bus);
          f_cnt = 0;
        end
      end
    end
  end

  always @(negedge i_clk)
    if (i_rst_n) begin
      n_init += int'(o_init);
      n_rd   += int'(o_cand_rd);
      n_fin  += int'(o_finish);
      n_ack  += int'(o_ack);
      n_rv   += int'(o_result_valid);
      if (int'(o_init) + int'(o_finish) + int'(o_ack) > 1) n_excl++;
    end

  task automatic run_search(input logic [7:0] num, input logic [255:0] ori, output int lat);
    @(negedge i_clk);
    i_num_cand = num;
    i_ori_in = ori;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    lat = 1;
    while (!o_result_valid && lat < 3000) begin
      @(negedge i_clk);
      lat++;
    end
    checks++;
    if (!o_result_valid) begin
      errors++;
      $display("FAIL result_wait: result_valid=%0b after %0d cycles, required 1", o_result_valid, lat);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_busy, o_result_valid, o_init, o_finish, o_ack, o_cand_rd, o_timeout_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0", {o_busy, o_result_valid, o_init, o_finish, o_ack, o_cand_rd, o_timeout_err});
    end
    checks++;
    if ({o_best_sad, o_best_idx, o_cand_addr} !== 29'b0 || o_ori_bus !== '0 || o_can_bus !== '0) begin
      errors++;
      $display("FAIL reset_data: best_sad=%0d best_idx=%0d addr=%0d, required 0", o_best_sad, o_best_idx, o_cand_addr);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_single();
    int lat, rv0;
    ram[0] = fill(8'd12);
    rv0 = n_rv;
    run_search(8'd1, fill(8'd10), lat);
    checks++;
    if (o_best_sad !== 13'd64 || o_best_idx !== 8'd0) begin
      errors++;
      $display("FAIL single_best: sad=%0d idx=%0d required 64 0", o_best_sad, o_best_idx);
    end
    checks++;
    if (o_timeout_err !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_flags: terr=%0b busy=%0b required 0 1", o_timeout_err, o_busy);
    end
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL single_latency: %0d cycles required 9", lat);
    end
    @(negedge i_clk);
    checks++;
    if (o_result_valid !== 1'b0 || o_busy !== 1'b0 || n_rv - rv0 !== 1) begin
      errors++;
      $display("FAIL single_pulse: rv=%0b busy=%0b pulses=%0d required 0 0 1", o_result_valid, o_busy, n_rv - rv0);
    end
  endtask

  task automatic test_multi();
    int lat, i0, r0;
    logic [255:0] b;
    ram[0] = pix0(8'd100);
    ram[1] = pix0(8'd40);
    b = '0;
    b[31:0] = {4{8'd10}};
    ram[2] = b;
    ram[3] = pix0(8'd200);
    i0 = n_init;
    r0 = n_rd;
    run_search(8'd4, '0, lat);
    checks++;
    if (o_best_sad !== 13'd40 || o_best_idx !== 8'd1) begin
      errors++;
      $display("FAIL multi_best: sad=%0d idx=%0d required 40 1", o_best_sad, o_best_idx);
    end
    checks++;
    if (n_init - i0 !== 4 || n_rd - r0 !== 4) begin
      errors++;
      $display("FAIL multi_counts: init=%0d rd=%0d required 4 4", n_init - i0, n_rd - r0);
    end
    checks++;
    if (lat !== 33 || o_cand_addr !== 8'd3) begin
      errors++;
      $display("FAIL multi_latency: %0d cycles addr=%0d required 33 3", lat, o_cand_addr);
    end
  endtask

  task automatic test_zero();
    int lat, i0, r0;
    i0 = n_init;
    r0 = n_rd;
    run_search(8'd0, fill(8'd5), lat);
    checks++;
    if (o_best_sad !== 13'd8191 || o_best_idx !== 8'd0) begin
      errors++;
      $display("FAIL zero_best: sad=%0d idx=%0d required 8191 0", o_best_sad, o_best_idx);
    end
    checks++;
    if (lat !== 1 || n_init - i0 !== 0 || n_rd - r0 !== 0) begin
      errors++;
      $display("FAIL zero_path: lat=%0d init=%0d rd=%0d required 1 0 0", lat, n_init - i0, n_rd - r0);
    end
  endtask

  task automatic test_timeout();
    int lat, f0;
    never_done = 1'b1;
    ram[0] = fill(8'd1);
    f0 = n_fin;
    run_search(8'd1, '0, lat);
    checks++;
    if (o_timeout_err !== 1'b1 || n_fin - f0 !== 64) begin
      errors++;
      $display("FAIL timeout_flag: terr=%0b finish_cycles=%0d required 1 64", o_timeout_err, n_fin - f0);
    end
    checks++;
    if (lat !== 68 || o_best_sad !== 13'd8191) begin
      errors++;
      $display("FAIL timeout_latency: lat=%0d sad=%0d required 68 8191", lat, o_best_sad);
    end
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0 || o_timeout_err !== 1'b1 || o_finish !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: busy=%0b terr=%0b finish=%0b required 0 1 0", o_busy, o_timeout_err, o_finish);
    end
    never_done = 1'b0;
  endtask

  task automatic test_ack_hold();
    int lat, a0, i0, v0, r0;
    ack_hold = 5;
    ram[0] = pix0(8'd50);
    ram[1] = pix0(8'd30);
    a0 = n_ack;
    i0 = n_init;
    v0 = n_rv;
    r0 = n_rd;
    @(negedge i_clk);
    i_num_cand = 8'd2;
    i_ori_in = '0;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    lat = 1;
    while (!o_result_valid && lat < 3000) begin
      @(negedge i_clk);
      lat++;
      i_start = (lat == 10);
      i_num_cand = (lat == 10) ? 8'd0 : 8'd2;
    end
    i_start = 1'b0;
    checks++;
    if (o_best_sad !== 13'd30 || o_best_idx !== 8'd1 || o_timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL ackhold_best: sad=%0d idx=%0d terr=%0b required 30 1 0", o_best_sad, o_best_idx, o_timeout_err);
    end
    checks++;
    if (n_ack - a0 !== 12 || n_rd - r0 !== 2) begin
      errors++;
      $display("FAIL ackhold_cycles: ack=%0d rd=%0d required 12 2", n_ack - a0, n_rd - r0);
    end
    repeat (3) @(negedge i_clk);
    checks++;
    if (n_init - i0 !== 2 || n_rv - v0 !== 1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_ignored: init=%0d rv=%0d busy=%0b required 2 1 0", n_init - i0, n_rv - v0, o_busy);
    end
    ack_hold = 0;
  endtask

  task automatic test_mid_reset();
    int n, lat, v0;
    ack_hold = 3;
    for (int k = 0; k < 4; k++) ram[k] = pix0(8'(20 + k));
    v0 = n_rv;
    @(negedge i_clk);
    i_num_cand = 8'd4;
    i_ori_in = '0;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    n = 0;
    while (!(o_ack && o_cand_addr == 8'd2) && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (!(o_ack && o_cand_addr == 8'd2)) begin
      errors++;
      $display("FAIL midrst_reach: ack=%0b addr=%0d required 1 2", o_ack, o_cand_addr);
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_ack, o_finish, o_init, o_cand_rd, o_result_valid} !== 6'b0 || {o_best_sad, o_best_idx, o_cand_addr} !== 29'b0 || o_can_bus !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: busy=%0b ack=%0b sad=%0d addr=%0d required all 0", o_busy, o_ack, o_best_sad, o_cand_addr);
    end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    ack_hold = 0;
    checks++;
    if (n_rv - v0 !== 0) begin
      errors++;
      $display("FAIL midrst_no_result: pulses=%0d required 0", n_rv - v0);
    end
    ram[0] = pix0(8'd77);
    run_search(8'd1, '0, lat);
    checks++;
    if (o_best_sad !== 13'd77 || o_best_idx !== 8'd0 || lat !== 9) begin
      errors++;
      $display("FAIL midrst_rerun: sad=%0d idx=%0d lat=%0d required 77 0 9", o_best_sad, o_best_idx, lat);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_timeout();
    test_ack_hold();
    test_mid_reset();
    checks++;
    if (n_excl !== 0) begin
      errors++;
      $display("FAIL handshake_exclusive: %0d overlapping cycles required 0", n_excl);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
